// File: rtl/crc_stream_param.sv
// Parametrised streaming CRC engine: one DATA_W beat per cycle through a parallel
// XOR network, then either appends the final CRC words or checks the frame residue.
module crc_stream_param #(
  parameter int              CRC_W   = 32,
  parameter int              DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT    = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit              REFIN   = 1'b1,
  parameter bit              REFOUT  = 1'b1,
  parameter logic [CRC_W-1:0] CHECK   = 32'h2144DF1C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              append_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CRC_W-1:0]  crc_value,
  output logic              crc_done,
  output logic              crc_ok
);

  localparam int WORDS = CRC_W / DATA_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  generate
    if ((CRC_W % DATA_W) != 0) begin : g_bad_width
      $error("crc_stream_param: CRC_W must be a multiple of DATA_W");
    end
  endgenerate

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_APPEND = 1'b1} state_t;

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // Unrolled at elaboration into a flat XOR network; the register stays MSB-first
  // and reflected input is handled by feeding data bit 0 first.
  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      fb = r[CRC_W-1] ^ (REFIN ? d[i] : d[DATA_W-1-i]);
      r  = (r << 1) ^ (fb ? POLY : {CRC_W{1'b0}});
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [CRC_W-1:0]    crc_value_q, crc_value_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                crc_done_q, crc_done_d;
  logic                crc_ok_q, crc_ok_d;
  logic                first_q, first_d;
  logic                append_q, append_d;

  logic                free_s, accept_s, mode_s;
  logic [CRC_W-1:0]    crc_nxt_s, crc_fin_s;
  logic [CNT_W-1:0]    widx_s;
  logic [DATA_W-1:0]   word_s;

  assign free_s    = ~m_valid_q | m_ready;
  assign s_ready   = (state_q == ST_RUN) & free_s;
  assign accept_s  = s_ready & s_valid;
  assign mode_s    = first_q ? append_en : append_q;
  assign crc_nxt_s = crc_next(crc_q, s_data);
  assign crc_fin_s = (REFOUT ? bitrev(crc_nxt_s) : crc_nxt_s) ^ XOR_OUT;
  // Reflected output goes out least-significant word first.
  assign widx_s    = REFOUT ? cnt_q : (LAST_WORD - cnt_q);
  assign word_s    = DATA_W'(crc_value_q >> (int'(widx_s) * DATA_W));

  // Next-state and output-register load logic for payload pass-through and CRC append.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    crc_value_d = crc_value_q;
    cnt_d       = cnt_q;
    m_valid_d   = free_s ? 1'b0 : m_valid_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    crc_done_d  = 1'b0;
    crc_ok_d    = crc_ok_q;
    first_d     = first_q;
    append_d    = append_q;
    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          crc_d     = crc_nxt_s;
          append_d  = mode_s;
          first_d   = s_last;
          if (s_last) begin
            crc_value_d = crc_fin_s;
            crc_done_d  = 1'b1;
            crc_ok_d    = (crc_fin_s == CHECK);
            crc_d       = INIT;
            if (mode_s) begin
              m_last_d = 1'b0;
              state_d  = ST_APPEND;
              cnt_d    = {CNT_W{1'b0}};
            end else begin
              m_last_d = 1'b1;
            end
          end else begin
            m_last_d = 1'b0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_APPEND: begin
        if (free_s) begin
          m_valid_d = 1'b1;
          m_data_d  = word_s;
          m_last_d  = (cnt_q == LAST_WORD);
          if (cnt_q == LAST_WORD) begin
            state_d = ST_RUN;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end else begin
          state_d = ST_APPEND;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      crc_q       <= INIT;
      crc_value_q <= {CRC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= {DATA_W{1'b0}};
      crc_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      first_q     <= 1'b1;
      append_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_value_q <= crc_value_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      crc_done_q  <= crc_done_d;
      crc_ok_q    <= crc_ok_d;
      first_q     <= first_d;
      append_q    <= append_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_data    = m_data_q;
  assign crc_value = crc_value_q;
  assign crc_done  = crc_done_q;
  assign crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_crc_stream_param.sv
// Directed bench for crc_stream_param: CRC-32 default instance plus a CRC-16/CCITT-FALSE instance.
module tb_crc_stream_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, append_en, s_last, m_ready, rnd_mode;
  logic        rnd_bit = 1'b1;
  logic [7:0]  s_data;
  logic        s_valid32, s_ready32, m_valid32, m_last32, crc_done32, crc_ok32;
  logic [7:0]  m_data32;
  logic [31:0] crc_value32;
  logic        s_valid16, s_ready16, m_valid16, m_last16, crc_done16, crc_ok16;
  logic [7:0]  m_data16;
  logic [15:0] crc_value16;

  int checks = 0;
  int errors = 0;
  logic [8:0] got32[$];
  logic [8:0] got16[$];
  logic [8:0] exp_q[$];
  int done_cnt32 = 0, done_cnt16 = 0, last_cnt32 = 0, last_cnt16 = 0;
  logic [31:0] val32;
  logic [15:0] val16;
  logic        ok32, ok16;

  assign m_ready = rnd_mode ? rnd_bit : 1'b1;
  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  crc_stream_param u_dut32 (
    .clk(clk), .rst(rst), .append_en(append_en),
    .s_valid(s_valid32), .s_ready(s_ready32), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid32), .m_ready(m_ready), .m_data(m_data32), .m_last(m_last32),
    .crc_value(crc_value32), .crc_done(crc_done32), .crc_ok(crc_ok32)
  );

  crc_stream_param #(
    .CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
    .REFIN(1'b0), .REFOUT(1'b0), .CHECK(16'h0000)
  ) u_dut16 (
    .clk(clk), .rst(rst), .append_en(append_en),
    .s_valid(s_valid16), .s_ready(s_ready16), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid16), .m_ready(m_ready), .m_data(m_data16), .m_last(m_last16),
    .crc_value(crc_value16), .crc_done(crc_done16), .crc_ok(crc_ok16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CRC-32 side monitor: latency, stall stability, s_ready low during append.
  logic       pend_beat = 1'b0, pend_last = 1'b0, pend_app = 1'b0, prev_hold = 1'b0;
  logic       app_phase = 1'b0, first_mon = 1'b1, mode_mon = 1'b0, cur_mode;
  logic [7:0] pend_byte;
  logic [9:0] prev_out;
  always @(negedge clk) begin
    if (!rst) begin
      pend_beat = 1'b0; pend_last = 1'b0; prev_hold = 1'b0;
      app_phase = 1'b0; first_mon = 1'b1; mode_mon = 1'b0;
    end else begin
      if (pend_beat) chk("lat_data", {m_valid32, m_data32}, {1'b1, pend_byte});
      if (pend_last) chk("lat_done", crc_done32, 1'b1);
      if (prev_hold) chk("stall_hold", {m_valid32, m_last32, m_data32}, prev_out);
      if (m_valid32 && m_ready && m_last32) app_phase = 1'b0;
      if (pend_last && pend_app) app_phase = 1'b1;
      if (app_phase) chk("s_ready_append", s_ready32, 1'b0);
      if (crc_done32) begin
        done_cnt32++; val32 = crc_value32; ok32 = crc_ok32;
      end
      if (m_valid32 && m_ready) begin
        got32.push_back({m_last32, m_data32});
        if (m_last32) last_cnt32++;
      end
      pend_beat = s_valid32 && s_ready32;
      pend_byte = s_data;
      pend_last = pend_beat && s_last;
      if (pend_beat) begin
        cur_mode  = first_mon ? append_en : mode_mon;
        mode_mon  = cur_mode;
        first_mon = s_last;
        pend_app  = cur_mode;
      end
      prev_hold = m_valid32 && !m_ready;
      prev_out  = {m_valid32, m_last32, m_data32};
    end
  end

  // CRC-16 side monitor: collects output beats and completed CRCs.
  always @(negedge clk) begin
    if (rst) begin
      if (crc_done16) begin
        done_cnt16++; val16 = crc_value16; ok16 = crc_ok16;
      end
      if (m_valid16 && m_ready) begin
        got16.push_back({m_last16, m_data16});
        if (m_last16) last_cnt16++;
      end
    end
  end

  task automatic send_beat(input bit sel, input logic [7:0] d, input bit last, output int waits);
    int n = 0;
    if (sel) s_valid16 = 1'b1; else s_valid32 = 1'b1;
    s_data = d;
    s_last = last;
    @(negedge clk);
    while (!(sel ? s_ready16 : s_ready32) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept", sel ? s_ready16 : s_ready32, 1'b1);
    @(posedge clk);
    #1;
    s_valid16 = 1'b0; s_valid32 = 1'b0; s_last = 1'b0;
    waits = n;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b[$], input bit app);
    int w;
    append_en = app;
    for (int i = 0; i < b.size(); i++) send_beat(sel, b[i], (i == b.size() - 1), w);
  endtask

  task automatic wait_last(input bit sel, input int target);
    int n = 0;
    while ((sel ? last_cnt16 : last_cnt32) < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("wait_last", ((sel ? last_cnt16 : last_cnt32) >= target), 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic add_frame(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) exp_q.push_back({(i == b.size() - 1), b[i]});
  endtask

  task automatic cmp_out(input string tag, input logic [8:0] got[$]);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
    exp_q.delete();
  endtask

  logic [7:0] msg9[$], frame13[$], bad13[$], frame11[$], crc32_b[$], crc16_b[$], zero_frame[$];
  int t, d0, w;

  initial begin
    msg9       = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    crc32_b    = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    crc16_b    = '{8'h29, 8'hB1};
    zero_frame = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    frame13    = msg9;
    for (int i = 0; i < 4; i++) frame13.push_back(crc32_b[i]);
    bad13      = frame13;
    bad13[0]   = 8'h30;
    frame11    = msg9;
    for (int i = 0; i < 2; i++) frame11.push_back(crc16_b[i]);

    rnd_mode = 1'b0; rst = 1'b0; append_en = 1'b0; s_data = 8'h00; s_last = 1'b0;
    s_valid32 = 1'b0; s_valid16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out32", {m_valid32, m_last32, crc_done32, crc_ok32, m_data32}, 32'h0);
    chk("rst_val32", crc_value32, 32'h0);
    chk("rst_rdy32", s_ready32, 1'b1);
    chk("rst_out16", {m_valid16, m_last16, crc_done16, crc_ok16, m_data16, crc_value16}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // CRC-32 generate over "123456789"
    t = last_cnt32 + 1; d0 = done_cnt32;
    send_frame(1'b0, msg9, 1'b1);
    wait_last(1'b0, t);
    add_frame(frame13); cmp_out("gen32_out", got32); got32.delete();
    chk("gen32_crc", val32, 32'hCBF43926);
    chk("gen32_ok", ok32, 1'b0);
    chk("gen32_done", done_cnt32 - d0, 32'd1);

    // Check the generated frame, then a corrupted copy
    t = last_cnt32 + 1;
    send_frame(1'b0, frame13, 1'b0);
    wait_last(1'b0, t);
    add_frame(frame13); cmp_out("chk32_out", got32); got32.delete();
    chk("chk32_crc", val32, 32'h2144DF1C);
    chk("chk32_ok", ok32, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("ok_hold", crc_ok32, 1'b1);
    t = last_cnt32 + 1;
    send_frame(1'b0, bad13, 1'b0);
    wait_last(1'b0, t);
    got32.delete();
    chk("bad32_ok", ok32, 1'b0);

    // CRC-16/CCITT-FALSE generate and re-check
    t = last_cnt16 + 1;
    send_frame(1'b1, msg9, 1'b1);
    wait_last(1'b1, t);
    add_frame(frame11); cmp_out("gen16_out", got16); got16.delete();
    chk("gen16_crc", val16, 16'h29B1);
    t = last_cnt16 + 1;
    send_frame(1'b1, frame11, 1'b0);
    wait_last(1'b1, t);
    got16.delete();
    chk("chk16_crc", val16, 16'h0000);
    chk("chk16_ok", ok16, 1'b1);
    chk("done16", done_cnt16, 32'd2);

    // Generate under random backpressure
    rnd_mode = 1'b1;
    t = last_cnt32 + 1;
    send_frame(1'b0, msg9, 1'b1);
    wait_last(1'b0, t);
    rnd_mode = 1'b0;
    add_frame(frame13); cmp_out("bp32_out", got32); got32.delete();
    chk("bp32_crc", val32, 32'hCBF43926);

    // Back-to-back: check frame (append_en raised mid-frame) then single-beat 0x00 generate
    t = last_cnt32 + 2; d0 = done_cnt32;
    append_en = 1'b0;
    send_beat(1'b0, msg9[0], 1'b0, w);
    append_en = 1'b1;
    for (int i = 1; i < 9; i++) send_beat(1'b0, msg9[i], (i == 8), w);
    send_beat(1'b0, 8'h00, 1'b1, w);
    chk("b2b_wait", w, 32'd0);
    wait_last(1'b0, t);
    add_frame(msg9); add_frame(zero_frame); cmp_out("b2b_out", got32); got32.delete();
    chk("b2b_crc", val32, 32'hD202EF8D);
    chk("b2b_done", done_cnt32 - d0, 32'd2);

    // Reset during the second payload byte, then a clean frame
    d0 = done_cnt32;
    append_en = 1'b1;
    send_beat(1'b0, 8'h31, 1'b0, w);
    s_valid32 = 1'b1; s_data = 8'h32;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out", {m_valid32, m_last32, crc_done32, crc_ok32, m_data32}, 32'h0);
    chk("midrst_val", crc_value32, 32'h0);
    s_valid32 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    got32.delete();
    t = last_cnt32 + 1;
    send_frame(1'b0, msg9, 1'b1);
    wait_last(1'b0, t);
    add_frame(frame13); cmp_out("post_rst_out", got32); got32.delete();
    chk("post_rst_crc", val32, 32'hCBF43926);
    chk("post_rst_done", done_cnt32 - d0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
